bus_cycle_unit: RTL and testbench

Machine-cycle sequencer between the instruction decoder and the external 8085-style multiplexed bus. It accepts one bus request at a time: a cycle type, a 16-bit address and write data. It then runs the T-state sequence T1/T2/[Twait]/T3/[T4], driving ALE, status, strobes and the AD mux, and returns captured read data with a done pulse. It also handles READY wait states, HOLD/HLDA bus release and the HALT state.

---
 rtl/bus_pkg.sv | 59 +++++
 rtl/bus_wait_ctl.sv | 40 ++++
 rtl/bus_cycle_unit.sv | 164 ++++++++++++++++
 tb/tb_bus_cycle_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types for the bus cycle sequencer: cycle kinds, T-states, status encoding.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bus_pkg;

    typedef enum logic [2:0] {
        CYC_OF   = 3'd0,
        CYC_MR   = 3'd1,
        CYC_MW   = 3'd2,
        CYC_IOR  = 3'd3,
        CYC_IOW  = 3'd4,
        CYC_INTA = 3'd5,
        CYC_HALT = 3'd6,
        CYC_RSVD = 3'd7
    } cycle_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_T1    = 3'd1,
        ST_T2    = 3'd2,
        ST_TW    = 3'd3,
        ST_T3    = 3'd4,
        ST_T4    = 3'd5,
        ST_THOLD = 3'd6,
        ST_THALT = 3'd7
    } tstate_t;

    typedef struct packed {
        logic s1;
        logic s0;
        logic iomn;
    } status_t;

    // S1/S0/IO-M encoding presented on the bus for each cycle kind.
    function automatic status_t cycle_status(cycle_t c);
        status_t st;
        case (c)
            CYC_OF:   st = '{s1: 1'b1, s0: 1'b1, iomn: 1'b0};
            CYC_MR:   st = '{s1: 1'b1, s0: 1'b0, iomn: 1'b0};
            CYC_MW:   st = '{s1: 1'b0, s0: 1'b1, iomn: 1'b0};
            CYC_IOR:  st = '{s1: 1'b1, s0: 1'b0, iomn: 1'b1};
            CYC_IOW:  st = '{s1: 1'b0, s0: 1'b1, iomn: 1'b1};
            CYC_INTA: st = '{s1: 1'b1, s0: 1'b1, iomn: 1'b1};
            default:  st = '{s1: 1'b0, s0: 1'b0, iomn: 1'b0};
        endcase
        return st;
    endfunction

    // Cycles whose T2..T3 assert RDn (INTA uses RDn as its strobe).
    function automatic logic uses_rd(cycle_t c);
        return (c == CYC_OF) || (c == CYC_MR) || (c == CYC_IOR) || (c == CYC_INTA);
    endfunction

    // Cycles that drive write data and assert WRn.
    function automatic logic is_write(cycle_t c);
        return (c == CYC_MW) || (c == CYC_IOW);
    endfunction

endpackage

// File: rtl/bus_wait_ctl.sv
// Wait-state qualifier: forces MIN_WAIT TW states, then waits for READY.
// Latency: go_t3_o is combinational from the counter and ready_i.
// Backpressure: holds go_t3_o low while the counter is non-zero or READY is low.
module bus_wait_ctl #(
    parameter int MIN_WAIT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic run_i,
    input  logic ready_i,
    output logic go_t3_o
);

    localparam logic [2:0] WAIT_INIT = 3'(MIN_WAIT);

    logic [2:0] cnt_q, cnt_d;

    // Preload during T1; count down once per edge spent leaving T2 or TW.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = WAIT_INIT;
        end else if (run_i && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign go_t3_o = (cnt_q == 3'd0) && ready_i;

endmodule

// File: rtl/bus_cycle_unit.sv
// 8085-style machine-cycle sequencer: T1/T2/[TW]/T3/[T4], HOLD and HALT handling.
// Latency: T1 on the edge that accepts req; done pulses the cycle after T3.
// Backpressure: bus_ready is low inside a cycle and whenever HOLD is requested.
module bus_cycle_unit
    import bus_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MIN_WAIT = 0
) (
    input  logic              phi1,
    input  logic              resetn_in,
    input  logic              req,
    input  logic [2:0]        cyc_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              bus_ready,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    input  logic              ready_in,
    input  logic              hold_in,
    output logic              hlda,
    output logic [7:0]        haddress,
    output logic [7:0]        ad_out,
    output logic              ad_oe,
    input  logic [7:0]        ad_in,
    output logic              ctl_oe,
    output logic              ALE,
    output logic              S0,
    output logic              S1,
    output logic              IOMn,
    output logic              RDn,
    output logic              WRn,
    output logic [2:0]        tstate
);

    tstate_t           state_q, state_d;
    cycle_t            typ_q, typ_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    status_t           status_q, status_d;
    logic              ale_q, ale_d, rdn_q, rdn_d, wrn_q, wrn_d;
    logic              ad_oe_q, ad_oe_d, ctl_oe_q, ctl_oe_d, hlda_q, hlda_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [7:0]        haddr_q, haddr_d, ad_out_q, ad_out_d;
    logic              accept, go_t3, in_strobe;

    // The only point where a new cycle may start; HOLD blocks acceptance.
    assign bus_ready = !hold_in &&
                       ((state_q == ST_IDLE) || (state_q == ST_THALT) || (state_q == ST_T4) ||
                        ((state_q == ST_T3) && (typ_q != CYC_OF)));
    assign accept    = req && bus_ready;

    bus_wait_ctl #(.MIN_WAIT(MIN_WAIT)) u_wait (
        .clk     (phi1),
        .rst_n   (resetn_in),
        .load_i  (state_q == ST_T1),
        .run_i   ((state_q == ST_T2) || (state_q == ST_TW)),
        .ready_i (ready_in),
        .go_t3_o (go_t3)
    );

    // Next-state logic; after a cycle's last T-state: new request, then HOLD, then idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_THALT: begin
                if (accept)       state_d = ST_T1;
                else if (hold_in) state_d = ST_THOLD;
            end
            ST_T1:    state_d = (typ_q == CYC_HALT) ? ST_THALT : ST_T2;
            ST_T2,
            ST_TW:    state_d = go_t3 ? ST_T3 : ST_TW;
            ST_T3,
            ST_T4: begin
                if ((state_q == ST_T3) && (typ_q == CYC_OF)) state_d = ST_T4;
                else if (accept)                             state_d = ST_T1;
                else if (hold_in)                            state_d = ST_THOLD;
                else                                         state_d = ST_IDLE;
            end
            ST_THOLD: state_d = hold_in ? ST_THOLD : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered pad values are derived from the state being entered at this edge.
    always_comb begin
        typ_d     = accept ? cycle_t'(cyc_type) : typ_q;
        wdata_d   = accept ? wdata : wdata_q;
        status_d  = accept ? cycle_status(cycle_t'(cyc_type)) : status_q;
        in_strobe = (state_d == ST_T2) || (state_d == ST_TW) || (state_d == ST_T3);
        ale_d     = (state_d == ST_T1);
        rdn_d     = !(in_strobe && uses_rd(typ_d));
        wrn_d     = !(in_strobe && is_write(typ_d));
        ad_oe_d   = (state_d == ST_T1) || (in_strobe && is_write(typ_d));
        ctl_oe_d  = (state_d != ST_THOLD);
        hlda_d    = (state_d == ST_THOLD);
        haddr_d   = haddr_q;
        ad_out_d  = ad_out_q;
        if (state_d == ST_T1) begin
            haddr_d  = addr[ADDR_W-1 -: 8];
            ad_out_d = addr[7:0];
        end else if ((state_d == ST_T2) && is_write(typ_d)) begin
            ad_out_d = wdata_d[7:0];
        end
        // T3 always ends the data phase of a non-HALT cycle, so that edge captures and reports.
        done_d    = (state_q == ST_T3);
        rd_data_d = rd_data_q;
        if ((state_q == ST_T3) && uses_rd(typ_q)) begin
            rd_data_d = DATA_W'(ad_in);
        end
    end

    // State and output registers; reset aborts any cycle in flight.
    always_ff @(posedge phi1 or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q   <= ST_IDLE;
            typ_q     <= CYC_OF;
            wdata_q   <= '0;
            status_q  <= '0;
            ale_q     <= 1'b0;
            rdn_q     <= 1'b1;
            wrn_q     <= 1'b1;
            ad_oe_q   <= 1'b0;
            ctl_oe_q  <= 1'b1;
            hlda_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            haddr_q   <= '0;
            ad_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            typ_q     <= typ_d;
            wdata_q   <= wdata_d;
            status_q  <= status_d;
            ale_q     <= ale_d;
            rdn_q     <= rdn_d;
            wrn_q     <= wrn_d;
            ad_oe_q   <= ad_oe_d;
            ctl_oe_q  <= ctl_oe_d;
            hlda_q    <= hlda_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            haddr_q   <= haddr_d;
            ad_out_q  <= ad_out_d;
        end
    end

    assign tstate   = state_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign hlda     = hlda_q;
    assign haddress = haddr_q;
    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;
    assign ctl_oe   = ctl_oe_q;
    assign ALE      = ale_q;
    assign S1       = status_q.s1;
    assign S0       = status_q.s0;
    assign IOMn     = status_q.iomn;
    assign RDn      = rdn_q;
    assign WRn      = wrn_q;

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Directed bench for bus_cycle_unit: two instances, MIN_WAIT=0 and MIN_WAIT=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_bus_cycle_unit;

    logic        phi1 = 1'b0;
    logic        resetn_in;
    logic        req, ready_in, hold_in;
    logic [2:0]  cyc_type;
    logic [15:0] addr;
    logic [7:0]  wdata, ad_in;
    logic        bus_ready, done, hlda, ad_oe, ctl_oe, ALE, S0, S1, IOMn, RDn, WRn;
    logic [7:0]  rd_data, haddress, ad_out;
    logic [2:0]  tstate;

    logic        req2, ready2, hold2;
    logic [2:0]  cyc2;
    logic [15:0] addr2;
    logic [7:0]  wdata2;
    logic        bus_ready2, done2, hlda2, ad_oe2, ctl_oe2, ALE2, S02, S12, IOMn2, RDn2, WRn2;
    logic [7:0]  rd_data2, haddress2, ad_out2;
    logic [2:0]  tstate2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 phi1 = ~phi1;

    bus_cycle_unit #(.ADDR_W(16), .DATA_W(8), .MIN_WAIT(0)) dut (
        .phi1(phi1), .resetn_in(resetn_in), .req(req), .cyc_type(cyc_type), .addr(addr),
        .wdata(wdata), .bus_ready(bus_ready), .done(done), .rd_data(rd_data),
        .ready_in(ready_in), .hold_in(hold_in), .hlda(hlda), .haddress(haddress),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .ctl_oe(ctl_oe), .ALE(ALE),
        .S0(S0), .S1(S1), .IOMn(IOMn), .RDn(RDn), .WRn(WRn), .tstate(tstate)
    );

    bus_cycle_unit #(.ADDR_W(16), .DATA_W(8), .MIN_WAIT(2)) dut2 (
        .phi1(phi1), .resetn_in(resetn_in), .req(req2), .cyc_type(cyc2), .addr(addr2),
        .wdata(wdata2), .bus_ready(bus_ready2), .done(done2), .rd_data(rd_data2),
        .ready_in(ready2), .hold_in(hold2), .hlda(hlda2), .haddress(haddress2),
        .ad_out(ad_out2), .ad_oe(ad_oe2), .ad_in(ad_in), .ctl_oe(ctl_oe2), .ALE(ALE2),
        .S0(S02), .S1(S12), .IOMn(IOMn2), .RDn(RDn2), .WRn(WRn2), .tstate(tstate2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so sampled values are settled.
    task automatic tick();
        @(posedge phi1);
        #1;
    endtask

    initial begin
        resetn_in = 1'b0; req = 1'b0; cyc_type = 3'd0; addr = '0; wdata = '0;
        ready_in = 1'b1; hold_in = 1'b0; ad_in = '0;
        req2 = 1'b0; cyc2 = 3'd0; addr2 = '0; wdata2 = '0; ready2 = 1'b1; hold2 = 1'b0;

        // Reset state
        #12;
        chk("rst_tstate", tstate, 0);
        chk("rst_RDn", RDn, 1);
        chk("rst_WRn", WRn, 1);
        chk("rst_ALE", ALE, 0);
        chk("rst_ctl_oe", ctl_oe, 1);
        chk("rst_ad_oe", ad_oe, 0);
        chk("rst_hlda", hlda, 0);
        chk("rst_done", done, 0);
        chk("rst_bus_ready", bus_ready, 1);
        resetn_in = 1'b1;

        // MR at 0x12A4, data 0x5C
        req = 1'b1; cyc_type = 3'd1; addr = 16'h12A4; ad_in = 8'h5C;
        tick();
        req = 1'b0;
        chk("mr_t1_state", tstate, 1);
        chk("mr_t1_ALE", ALE, 1);
        chk("mr_t1_haddr", haddress, 8'h12);
        chk("mr_t1_adout", ad_out, 8'hA4);
        chk("mr_t1_adoe", ad_oe, 1);
        chk("mr_status", {S1, S0, IOMn}, 3'b100);
        tick();
        chk("mr_t2_state", tstate, 2);
        chk("mr_t2_ALE", ALE, 0);
        chk("mr_t2_RDn", RDn, 0);
        chk("mr_t2_adoe", ad_oe, 0);
        tick();
        chk("mr_t3_state", tstate, 4);
        chk("mr_t3_RDn", RDn, 0);
        chk("mr_t3_done", done, 0);
        tick();
        chk("mr_done", done, 1);
        chk("mr_rd_data", rd_data, 8'h5C);
        chk("mr_end_RDn", RDn, 1);
        chk("mr_end_state", tstate, 0);
        tick();
        chk("mr_done_pulse", done, 0);

        // MW at 0x8001, data 0x3F, READY low for two samples
        req = 1'b1; cyc_type = 3'd2; addr = 16'h8001; wdata = 8'h3F;
        tick();
        req = 1'b0; ready_in = 1'b0;
        chk("mw_t1_haddr", haddress, 8'h80);
        chk("mw_t1_adout", ad_out, 8'h01);
        tick();
        chk("mw_t2_state", tstate, 2);
        chk("mw_t2_WRn", WRn, 0);
        chk("mw_t2_adout", ad_out, 8'h3F);
        chk("mw_status", {S1, S0, IOMn}, 3'b010);
        tick();
        chk("mw_tw1_state", tstate, 3);
        chk("mw_tw1_WRn", WRn, 0);
        tick();
        ready_in = 1'b1;
        chk("mw_tw2_state", tstate, 3);
        chk("mw_tw2_adoe", ad_oe, 1);
        tick();
        chk("mw_t3_state", tstate, 4);
        chk("mw_t3_WRn", WRn, 0);
        chk("mw_t3_adout", ad_out, 8'h3F);
        tick();
        chk("mw_end_WRn", WRn, 1);
        chk("mw_done", done, 1);

        // OF at 0x2000 then IOR at 0x0042 back to back
        req = 1'b1; cyc_type = 3'd0; addr = 16'h2000; ad_in = 8'hAA;
        tick();
        cyc_type = 3'd3; addr = 16'h0042;
        chk("of_t1_state", tstate, 1);
        chk("of_status", {S1, S0, IOMn}, 3'b110);
        tick();
        tick();
        chk("of_t3_state", tstate, 4);
        chk("of_t3_bus_ready", bus_ready, 0);
        tick();
        chk("of_t4_state", tstate, 5);
        chk("of_t4_RDn", RDn, 1);
        chk("of_t4_adoe", ad_oe, 0);
        chk("of_done", done, 1);
        chk("of_rd_data", rd_data, 8'hAA);
        chk("of_t4_bus_ready", bus_ready, 1);
        ad_in = 8'h77;
        tick();
        req = 1'b0;
        chk("ior_t1_state", tstate, 1);
        chk("ior_status", {S1, S0, IOMn}, 3'b101);
        chk("ior_t1_adout", ad_out, 8'h42);
        chk("ior_t1_done", done, 0);
        tick();
        tick();
        tick();
        chk("ior_done", done, 1);
        chk("ior_rd_data", rd_data, 8'h77);

        // HOLD raised during MR T2
        req = 1'b1; cyc_type = 3'd1; addr = 16'h0100;
        tick();
        req = 1'b0;
        tick();
        hold_in = 1'b1;
        #1;
        chk("hold_t2_bus_ready", bus_ready, 0);
        tick();
        chk("hold_t3_state", tstate, 4);
        chk("hold_t3_hlda", hlda, 0);
        tick();
        chk("hold_state", tstate, 6);
        chk("hold_hlda", hlda, 1);
        chk("hold_ctl_oe", ctl_oe, 0);
        chk("hold_done", done, 1);
        tick();
        chk("hold_stay", tstate, 6);
        hold_in = 1'b0;
        tick();
        chk("unhold_hlda", hlda, 0);
        chk("unhold_state", tstate, 0);
        chk("unhold_ctl_oe", ctl_oe, 1);

        // Reset asserted in TW of an MW
        ready_in = 1'b0;
        req = 1'b1; cyc_type = 3'd2; addr = 16'h4444; wdata = 8'h99;
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("rstmw_tw_state", tstate, 3);
        #2 resetn_in = 1'b0;
        #1;
        chk("rstmw_WRn", WRn, 1);
        chk("rstmw_adoe", ad_oe, 0);
        chk("rstmw_state", tstate, 0);
        chk("rstmw_done", done, 0);
        tick();
        chk("rstmw_done_after", done, 0);
        ready_in = 1'b1;
        resetn_in = 1'b1;
        tick();
        chk("rstmw_idle", tstate, 0);

        // MIN_WAIT=2, READY high: MR then HALT
        req2 = 1'b1; cyc2 = 3'd1; addr2 = 16'h0033;
        tick();
        req2 = 1'b0;
        chk("mw2_t1", tstate2, 1);
        tick();
        chk("mw2_t2", tstate2, 2);
        tick();
        chk("mw2_tw1", tstate2, 3);
        tick();
        chk("mw2_tw2", tstate2, 3);
        tick();
        chk("mw2_t3", tstate2, 4);
        tick();
        chk("mw2_done", done2, 1);
        req2 = 1'b1; cyc2 = 3'd6; addr2 = 16'hBEEF;
        tick();
        req2 = 1'b0;
        chk("halt_t1", tstate2, 1);
        chk("halt_ALE", ALE2, 1);
        chk("halt_haddr", haddress2, 8'hBE);
        tick();
        chk("halt_state", tstate2, 7);
        chk("halt_status", {S12, S02, IOMn2}, 3'b000);
        chk("halt_RDn", RDn2, 1);
        chk("halt_adoe", ad_oe2, 0);
        chk("halt_done", done2, 0);
        tick();
        chk("halt_stay", tstate2, 7);
        chk("halt_done2", done2, 0);
        chk("halt_bus_ready", bus_ready2, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
